// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time generator.
//   DT_W_DEFAULT : default width of the dead_time input and dead-time counter
//   state_e      : one-hot FSM encoding (S_OFF, S_LS, S_DT_RISE, S_HS, S_DT_FALL)
//   IDX_*        : bit positions of the states, used for direct output decode
package pwm_pkg;

  localparam int unsigned DT_W_DEFAULT = 8;

  localparam int unsigned IDX_LS      = 1;
  localparam int unsigned IDX_DT_RISE = 2;
  localparam int unsigned IDX_HS      = 3;
  localparam int unsigned IDX_DT_FALL = 4;

  typedef enum logic [4:0] {
    S_OFF     = 5'b00001,
    S_LS      = 5'b00010,
    S_DT_RISE = 5'b00100,
    S_HS      = 5'b01000,
    S_DT_FALL = 5'b10000
  } state_e;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Control/status bundle of the PWM dead-time generator.
//   ena, pwm_in, dead_time, fault_in, clr_fault : controls driven by the master
//   pwm_hs, pwm_ls, dt_active, fault_latched    : gate drives and status from the slave
interface pwm_deadtime_gen_if
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
);

  logic            ena;
  logic            pwm_in;
  logic [DT_W-1:0] dead_time;
  logic            fault_in;
  logic            clr_fault;
  logic            pwm_hs;
  logic            pwm_ls;
  logic            dt_active;
  logic            fault_latched;

  modport master (
    output ena, pwm_in, dead_time, fault_in, clr_fault,
    input  pwm_hs, pwm_ls, dt_active, fault_latched
  );

  modport slave (
    input  ena, pwm_in, dead_time, fault_in, clr_fault,
    output pwm_hs, pwm_ls, dt_active, fault_latched
  );

endinterface

// File: rtl/pwm_dt_timer.sv
// Dead-time down-counter.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val into the counter (has priority over dec)
//   dec       : decrement by one, holding at zero
//   load_val  : value to load
//   zero      : counter is zero
module pwm_dt_timer #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [DT_W-1:0] load_val,
  output logic            zero
);

  logic [DT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with programmable dead time and fault shutdown.
// The high side and low side are never on in the same cycle.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of pwm_deadtime_gen_if (controls in, gate drives and status out)
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  pwm_deadtime_gen_if.slave bus
);

  logic   pwm_q;
  logic   fault_latched_q;
  state_e state_q, state_d;
  logic   cnt_load, cnt_dec, cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= bus.pwm_in;
    end
  end

  // A fault present on the same edge as a clear request wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latched_q <= 1'b0;
    end else if (bus.fault_in) begin
      fault_latched_q <= 1'b1;
    end else if (bus.clr_fault) begin
      fault_latched_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (bus.fault_in || !bus.ena) begin
      state_d = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF: begin
          // Leaving OFF always starts with a full dead interval.
          if (!fault_latched_q) begin
            state_d  = pwm_q ? S_DT_RISE : S_DT_FALL;
            cnt_load = 1'b1;
          end
        end
        S_LS: begin
          if (pwm_q) begin
            state_d  = S_DT_RISE;
            cnt_load = 1'b1;
          end
        end
        S_DT_RISE: begin
          // Returning to LS is safe: HS was never turned on.
          if (!pwm_q) begin
            state_d = S_LS;
          end else if (cnt_zero) begin
            state_d = S_HS;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_HS: begin
          if (!pwm_q) begin
            state_d  = S_DT_FALL;
            cnt_load = 1'b1;
          end
        end
        S_DT_FALL: begin
          if (pwm_q) begin
            state_d = S_HS;
          end else if (cnt_zero) begin
            state_d = S_LS;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  pwm_dt_timer #(
    .DT_W(DT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(bus.dead_time),
    .zero    (cnt_zero)
  );

  // Outputs come straight off the one-hot state flops, so they are glitch-free.
  assign bus.pwm_hs        = state_q[IDX_HS];
  assign bus.pwm_ls        = state_q[IDX_LS];
  assign bus.dt_active     = state_q[IDX_DT_RISE] | state_q[IDX_DT_FALL];
  assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed and random-stress bench for pwm_deadtime_gen.
module tb_pwm_deadtime_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   stress = 1'b0;
  int   low_run = 0;
  int   last_on = 0;  // 0: none/off, 1: hs, 2: ls

  pwm_deadtime_gen_if #(.DT_W(8)) bus ();

  pwm_deadtime_gen #(
    .DT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      $error("%s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("no_shoot_through", bus.pwm_hs & bus.pwm_ls, 1'b0);
    if (stress) begin
      if (bus.pwm_hs && last_on == 2)
        check("gap_ls_to_hs", low_run >= int'(bus.dead_time) + 1, 1'b1);
      if (bus.pwm_ls && last_on == 1)
        check("gap_hs_to_ls", low_run >= int'(bus.dead_time) + 1, 1'b1);
    end
    if (bus.pwm_hs) begin
      last_on = 1;
      low_run = 0;
    end else if (bus.pwm_ls) begin
      last_on = 2;
      low_run = 0;
    end else begin
      low_run++;
      if (!bus.dt_active) last_on = 0;
    end
  endtask

  task automatic expect_n(input string tag, input int n, input logic ehs, input logic els,
                          input logic edt);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_hs"}, bus.pwm_hs, ehs);
      check({tag, "_ls"}, bus.pwm_ls, els);
      check({tag, "_dt"}, bus.dt_active, edt);
    end
  endtask

  initial begin
    logic [1:0] pat [10];
    int m;
    pat = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};

    rst           = 1'b1;
    bus.ena       = 1'b0;
    bus.pwm_in    = 1'b0;
    bus.dead_time = 8'd3;
    bus.fault_in  = 1'b0;
    bus.clr_fault = 1'b0;
    tick();
    tick();
    check("rst_hs", bus.pwm_hs, 1'b0);
    check("rst_ls", bus.pwm_ls, 1'b0);
    check("rst_dt", bus.dt_active, 1'b0);
    check("rst_fault", bus.fault_latched, 1'b0);

    // Enable with pwm low: full 4-cycle dead interval, then low side.
    rst     = 1'b0;
    bus.ena = 1'b1;
    expect_n("start_dt", 4, 1'b0, 1'b0, 1'b1);
    expect_n("start_ls", 1, 1'b0, 1'b1, 1'b0);

    // Rising edge, dead_time=3: ls drops at k+1, hs rises at k+5.
    bus.pwm_in = 1'b1;
    expect_n("rise3_k", 1, 1'b0, 1'b1, 1'b0);
    expect_n("rise3_dt", 4, 1'b0, 1'b0, 1'b1);
    expect_n("rise3_hs", 2, 1'b1, 1'b0, 1'b0);

    // dead_time=0, 10-cycle period, 50% duty, two periods.
    bus.dead_time = 8'd0;
    for (int c = 0; c < 20; c++) begin
      m = c % 10;
      bus.pwm_in = (m >= 5);
      tick();
      check("p10_hs", bus.pwm_hs, pat[m][1]);
      check("p10_ls", bus.pwm_ls, pat[m][0]);
      check("p10_dt", bus.dt_active, (m == 1) || (m == 6));
    end

    // Falling edge with dead_time=5: 6 cycles of dead time.
    bus.dead_time = 8'd5;
    bus.pwm_in    = 1'b0;
    expect_n("fall5_k", 1, 1'b1, 1'b0, 1'b0);
    expect_n("fall5_dt", 6, 1'b0, 1'b0, 1'b1);
    expect_n("fall5_ls", 1, 1'b0, 1'b1, 1'b0);

    // 2-cycle pulse shorter than the dead interval aborts back to ls.
    bus.pwm_in = 1'b1;
    expect_n("pulse_k", 1, 1'b0, 1'b1, 1'b0);
    expect_n("pulse_dt", 1, 1'b0, 0, 1'b1);
    bus.pwm_in = 1'b0;
    expect_n("pulse_dt2", 1, 1'b0, 1'b0, 1'b1);
    expect_n("pulse_abort", 4, 1'b0, 1'b1, 1'b0);

    // Reach hs with dead_time=1, then fault.
    bus.dead_time = 8'd1;
    bus.pwm_in    = 1'b1;
    expect_n("rise1_k", 1, 1'b0, 1'b1, 1'b0);
    expect_n("rise1_dt", 2, 1'b0, 1'b0, 1'b1);
    expect_n("rise1_hs", 1, 1'b1, 1'b0, 1'b0);
    bus.fault_in = 1'b1;
    tick();
    check("fault_hs", bus.pwm_hs, 1'b0);
    check("fault_ls", bus.pwm_ls, 1'b0);
    check("fault_set", bus.fault_latched, 1'b1);
    bus.fault_in = 1'b0;
    expect_n("fault_hold", 1, 1'b0, 1'b0, 1'b0);
    check("fault_sticky", bus.fault_latched, 1'b1);
    bus.fault_in  = 1'b1;
    bus.clr_fault = 1'b1;
    tick();
    check("clr_ignored", bus.fault_latched, 1'b1);
    check("clr_ignored_hs", bus.pwm_hs, 1'b0);
    bus.fault_in = 1'b0;
    tick();
    check("clr_done", bus.fault_latched, 1'b0);
    check("clr_off_dt", bus.dt_active, 1'b0);
    check("clr_off_hs", bus.pwm_hs, 1'b0);
    bus.clr_fault = 1'b0;
    expect_n("restart_dt", 2, 1'b0, 1'b0, 1'b1);
    expect_n("restart_hs", 1, 1'b1, 1'b0, 1'b0);

    // Disable for one cycle, re-enable through a full dead interval.
    bus.ena = 1'b0;
    expect_n("dis", 1, 1'b0, 1'b0, 1'b0);
    bus.ena = 1'b1;
    expect_n("reena_dt", 2, 1'b0, 1'b0, 1'b1);
    expect_n("reena_hs", 1, 1'b1, 1'b0, 1'b0);

    // dead_time change mid-interval does not disturb the running count.
    bus.dead_time = 8'd2;
    bus.pwm_in    = 1'b0;
    expect_n("fall2_k", 1, 1'b1, 1'b0, 1'b0);
    expect_n("fall2_dt", 1, 1'b0, 1'b0, 1'b1);
    bus.dead_time = 8'd7;
    expect_n("fall2_dt_rest", 2, 1'b0, 1'b0, 1'b1);
    expect_n("fall2_ls", 1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a dead interval.
    bus.pwm_in = 1'b1;
    expect_n("rise7_k", 1, 1'b0, 1'b1, 1'b0);
    expect_n("rise7_dt", 3, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    expect_n("midrst", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_n("post_rst_dt", 1, 1'b0, 1'b0, 1'b1);
    expect_n("post_rst_hs", 1, 1'b1, 1'b0, 1'b0);

    // Random stress with constant dead time.
    bus.dead_time = 8'd2;
    rst           = 1'b1;
    tick();
    rst     = 1'b0;
    last_on = 0;
    low_run = 0;
    stress  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) bus.pwm_in = ~bus.pwm_in;
      bus.ena       = ($urandom_range(63) != 0);
      bus.fault_in  = ($urandom_range(99) == 0);
      bus.clr_fault = ($urandom_range(7) == 0);
      rst           = ($urandom_range(199) == 0);
      tick();
    end
    stress = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
